// File: rtl/jtag_fifo_shift_out_reader.sv
// jtag_fifo_shift_out_reader
// Read-side consumer of the JTAG shift-out FIFO. Words are fetched with a
// one-cycle read strobe, parked in a next-word buffer, then moved into a
// shift register that is drained LSB-first onto tdo, one bit per shift_en.
module jtag_fifo_shift_out_reader #(
   parameter int   DATA_WIDTH = 32,
   parameter logic IDLE_BIT   = 1'b0,
   parameter int   CNT_WIDTH  = 16
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic                  rempty,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  r_en,
   input  logic                  shift_en,
   input  logic                  flush,
   output logic                  tdo,
   output logic                  tdo_vld,
   output logic                  word_done,
   output logic                  underrun,
   output logic [CNT_WIDTH-1:0]  words_sent
);

   localparam int             BW       = $clog2(DATA_WIDTH);
   localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_WIDTH - 1);

   // Next-word buffer and outstanding-read tracking
   logic [DATA_WIDTH-1:0] r_nbuf;
   logic                  r_nbuf_vld;
   logic                  r_rd_pend;

   // Shift register holding the word currently on tdo
   logic [DATA_WIDTH-1:0] r_sreg;
   logic                  r_sreg_vld;
   logic [BW-1:0]         r_bcnt;

   // Registered status outputs
   logic                  r_word_done;
   logic                  r_underrun;
   logic [CNT_WIDTH-1:0]  r_words_sent;

   logic                  w_fetch;
   logic                  w_shift;
   logic                  w_last;
   logic                  w_load;
   logic [DATA_WIDTH-1:0] w_sreg_shr;

   // Only one word may be in flight or buffered; reset also forces the
   // strobe low so a mid-operation reset cannot pop a word.
   assign w_fetch = rrst_n && !rempty && !r_nbuf_vld && !r_rd_pend && !flush;
   assign r_en    = w_fetch;

   assign w_shift = shift_en && r_sreg_vld;
   assign w_last  = w_shift && (r_bcnt == LAST_BIT);
   // The shift register is free when empty or when its last bit leaves now,
   // which is what gives back-to-back words without an idle bit.
   assign w_load  = r_nbuf_vld && (!r_sreg_vld || w_last);

   // Right shift by one, zero-filling the MSB
   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_shr
         if (gi == DATA_WIDTH - 1) begin : g_msb
            assign w_sreg_shr[gi] = 1'b0;
         end else begin : g_bit
            assign w_sreg_shr[gi] = r_sreg[gi+1];
         end
      end
   endgenerate

   // Fetch side: mark the read pending, capture rdata one cycle later,
   // release the buffer when its word moves into the shift register
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_rd_pend  <= 1'b0;
         r_nbuf_vld <= 1'b0;
         r_nbuf     <= '0;
      end else if (flush) begin
         // a pending read's data is simply never captured
         r_rd_pend  <= 1'b0;
         r_nbuf_vld <= 1'b0;
      end else if (w_fetch) begin
         r_rd_pend  <= 1'b1;
      end else if (r_rd_pend) begin
         r_rd_pend  <= 1'b0;
         r_nbuf     <= rdata;
         r_nbuf_vld <= 1'b1;
      end else if (w_load) begin
         r_nbuf_vld <= 1'b0;
      end
   end

   // Shift side: load from the buffer, shift on shift_en, retire on last bit
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_sreg     <= '0;
         r_sreg_vld <= 1'b0;
         r_bcnt     <= '0;
      end else if (flush) begin
         r_sreg_vld <= 1'b0;
         r_bcnt     <= '0;
      end else if (w_load) begin
         r_sreg     <= r_nbuf;
         r_sreg_vld <= 1'b1;
         r_bcnt     <= '0;
      end else if (w_last) begin
         r_sreg_vld <= 1'b0;
         r_bcnt     <= '0;
      end else if (w_shift) begin
         r_sreg     <= w_sreg_shr;
         r_bcnt     <= r_bcnt + BW'(1);
      end
   end

   // Status: completion pulse, underrun pulse and the wrapping word counter
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_word_done  <= 1'b0;
         r_underrun   <= 1'b0;
         r_words_sent <= '0;
      end else begin
         r_word_done <= w_last && !flush;
         r_underrun  <= shift_en && !r_sreg_vld;
         if (w_last && !flush) begin
            r_words_sent <= r_words_sent + CNT_WIDTH'(1);
         end
      end
   end

   assign tdo        = r_sreg_vld ? r_sreg[0] : IDLE_BIT;
   assign tdo_vld    = r_sreg_vld;
   assign word_done  = r_word_done;
   assign underrun   = r_underrun;
   assign words_sent = r_words_sent;

endmodule
